alu_exec_unit: RTL and testbench

//  Execute-stage arithmetic block of the 5-stage MIPS pipeline: secondary ALU decoder (funct ->

---
 rtl/alu_exec_unit.sv | 110 +++++++++++
 tb/tb_alu_exec_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block: secondary ALU decoder, ALU with zero flag,
// branch-target adder, and a stallable EX/MEM copy of the ALU result.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [3:0]       alu_ctrl_in,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] sign_imm,
  output logic [3:0]       alu_ctrl_final,
  output logic             multiply,
  output logic             mfhi,
  output logic             mflo,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic [WIDTH-1:0] alu_out_q,
  output logic             zero_q
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SLL  = 4'b1001,
    OP_SRL  = 4'b1010,
    OP_SRA  = 4'b1011,
    OP_NOR  = 4'b1100,
    OP_LUI  = 4'b1101,
    OP_RTYPE = 4'b1111
  } aluOp_e;

  logic [4:0] shamt;
  logic       ltSigned;
  logic       ltUnsigned;

  always_comb begin
    alu_ctrl_final = alu_ctrl_in;
    multiply       = 1'b0;
    mfhi           = 1'b0;
    mflo           = 1'b0;
    if (alu_ctrl_in == OP_RTYPE) begin
      alu_ctrl_final = OP_ADD;
      unique case (funct)
        6'h20, 6'h21: alu_ctrl_final = OP_ADD;
        6'h22, 6'h23: alu_ctrl_final = OP_SUB;
        6'h24:        alu_ctrl_final = OP_AND;
        6'h25:        alu_ctrl_final = OP_OR;
        6'h26:        alu_ctrl_final = OP_XOR;
        6'h27:        alu_ctrl_final = OP_NOR;
        6'h2A:        alu_ctrl_final = OP_SLT;
        6'h2B:        alu_ctrl_final = OP_SLTU;
        6'h00:        alu_ctrl_final = OP_SLL;
        6'h02:        alu_ctrl_final = OP_SRL;
        6'h03:        alu_ctrl_final = OP_SRA;
        6'h18:        multiply = 1'b1;
        6'h10:        mfhi     = 1'b1;
        6'h12:        mflo     = 1'b1;
        default:      alu_ctrl_final = OP_ADD;
      endcase
    end
  end

  // Shift amount arrives on src_a: the datapath muxes shamt there.
  assign shamt      = src_a[4:0];
  assign ltSigned   = $signed(src_a) < $signed(src_b);
  assign ltUnsigned = src_a < src_b;

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_final)
      OP_AND:  alu_out = src_a & src_b;
      OP_OR:   alu_out = src_a | src_b;
      OP_ADD:  alu_out = src_a + src_b;
      OP_XOR:  alu_out = src_a ^ src_b;
      OP_SUB:  alu_out = src_a - src_b;
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ltSigned};
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, ltUnsigned};
      OP_SLL:  alu_out = src_b << shamt;
      OP_SRL:  alu_out = src_b >> shamt;
      OP_SRA:  alu_out = $signed(src_b) >>> shamt;
      OP_NOR:  alu_out = ~(src_a | src_b);
      OP_LUI:  alu_out = src_b << 16;
      default: alu_out = '0;
    endcase
  end

  assign zero          = (alu_out == '0);
  assign branch_target = pc_plus4 + (sign_imm << 2);

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
    end else if (!stall) begin
      alu_out_q <= alu_out;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver queues hand-computed expectations,
// a monitor checks combinational outputs mid-cycle and the register after the edge.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [3:0]  alu_ctrl_in;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, pc_plus4, sign_imm;
  logic [3:0]  alu_ctrl_final;
  logic        multiply, mfhi, mflo, zero, zero_q;
  logic [31:0] alu_out, branch_target, alu_out_q;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .alu_ctrl_in(alu_ctrl_in), .funct(funct),
    .src_a(src_a), .src_b(src_b), .pc_plus4(pc_plus4), .sign_imm(sign_imm),
    .alu_ctrl_final(alu_ctrl_final), .multiply(multiply), .mfhi(mfhi), .mflo(mflo),
    .alu_out(alu_out), .zero(zero), .branch_target(branch_target),
    .alu_out_q(alu_out_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] out;
    logic        z;
    logic [3:0]  ctrl;
    logic [2:0]  flags;   // {multiply, mfhi, mflo}
    logic [31:0] bt;
    logic [31:0] q;
    logic        zq;
  } exp_t;

  exp_t scoreQ[$];
  int testsRun = 0;
  int testsFailed = 0;
  int pushed = 0;
  int retired = 0;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge and queue what the DUT must show.
  task automatic addVec(input logic r, input logic s, input logic [3:0] c, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] eOut, input logic eZ, input logic [3:0] eCtrl,
                        input logic [2:0] eFlags, input logic [31:0] eBt,
                        input logic [31:0] eQ, input logic eZq);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; stall = s; alu_ctrl_in = c; funct = f;
    src_a = a; src_b = b; pc_plus4 = pc; sign_imm = imm;
    e.id = pushed; e.out = eOut; e.z = eZ; e.ctrl = eCtrl; e.flags = eFlags;
    e.bt = eBt; e.q = eQ; e.zq = eZq;
    scoreQ.push_back(e);
    pushed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        check("alu_out", e.id, alu_out, e.out);
        check("zero", e.id, {31'b0, zero}, {31'b0, e.z});
        check("alu_ctrl_final", e.id, {28'b0, alu_ctrl_final}, {28'b0, e.ctrl});
        check("flags", e.id, {29'b0, multiply, mfhi, mflo}, {29'b0, e.flags});
        check("branch_target", e.id, branch_target, e.bt);
        @(posedge clk);
        #1;
        check("alu_out_q", e.id, alu_out_q, e.q);
        check("zero_q", e.id, {31'b0, zero_q}, {31'b0, e.zq});
        retired++;
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b1; stall = 1'b0; alu_ctrl_in = '0; funct = '0;
    src_a = '0; src_b = '0; pc_plus4 = '0; sign_imm = '0;
    //     r  s  ctrl     funct  a             b             pc            imm           out           z  ctrl    flags   bt            q             zq
    addVec(1, 0, 4'hF, 6'h20, 32'd7,        32'd5,        32'h0,        32'h0,        32'd12,       0, 4'h2, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 0, 4'hF, 6'h20, 32'd7,        32'd5,        32'h0,        32'h0,        32'd12,       0, 4'h2, 3'b000, 32'h0,        32'd12,       0);
    addVec(0, 0, 4'h6, 6'h00, 32'd5,        32'd5,        32'h0,        32'h0,        32'h0,        1, 4'h6, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 0, 4'h6, 6'h00, 32'd0,        32'd1,        32'h0,        32'h0,        32'hFFFFFFFF, 0, 4'h6, 3'b000, 32'h0,        32'hFFFFFFFF, 0);
    addVec(0, 0, 4'h7, 6'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'd1,        0, 4'h7, 3'b000, 32'h0,        32'd1,        0);
    addVec(0, 0, 4'h8, 6'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'd0,        1, 4'h8, 3'b000, 32'h0,        32'd0,        1);
    addVec(0, 0, 4'h7, 6'h00, 32'h80000000, 32'h7FFFFFFF, 32'h0,        32'h0,        32'd1,        0, 4'h7, 3'b000, 32'h0,        32'd1,        0);
    addVec(0, 0, 4'hF, 6'h18, 32'd3,        32'd4,        32'h0,        32'h0,        32'd7,        0, 4'h2, 3'b100, 32'h0,        32'd7,        0);
    addVec(0, 0, 4'hF, 6'h12, 32'd3,        32'd4,        32'h0,        32'h0,        32'd7,        0, 4'h2, 3'b001, 32'h0,        32'd7,        0);
    addVec(0, 0, 4'hF, 6'h10, 32'd3,        32'd4,        32'h0,        32'h0,        32'd7,        0, 4'h2, 3'b010, 32'h0,        32'd7,        0);
    addVec(0, 0, 4'h1, 6'h18, 32'hF0,       32'h0F,       32'h0,        32'h0,        32'hFF,       0, 4'h1, 3'b000, 32'h0,        32'hFF,       0);
    addVec(0, 0, 4'h0, 6'h00, 32'hF0,       32'h3C,       32'h00400004, 32'hFFFFFFFE, 32'h30,       0, 4'h0, 3'b000, 32'h003FFFFC, 32'h30,       0);
    addVec(0, 0, 4'h3, 6'h00, 32'hFF,       32'h0F,       32'h00400004, 32'h3,        32'hF0,       0, 4'h3, 3'b000, 32'h00400010, 32'hF0,       0);
    addVec(0, 0, 4'hF, 6'h00, 32'd4,        32'd1,        32'h0,        32'h0,        32'h10,       0, 4'h9, 3'b000, 32'h0,        32'h10,       0);
    addVec(0, 0, 4'hF, 6'h02, 32'd4,        32'h80000000, 32'h0,        32'h0,        32'h08000000, 0, 4'hA, 3'b000, 32'h0,        32'h08000000, 0);
    addVec(0, 0, 4'hF, 6'h03, 32'd4,        32'h80000000, 32'h0,        32'h0,        32'hF8000000, 0, 4'hB, 3'b000, 32'h0,        32'hF8000000, 0);
    addVec(0, 0, 4'hF, 6'h27, 32'd0,        32'd0,        32'h0,        32'h0,        32'hFFFFFFFF, 0, 4'hC, 3'b000, 32'h0,        32'hFFFFFFFF, 0);
    addVec(0, 0, 4'hD, 6'h00, 32'd0,        32'h0000ABCD, 32'h0,        32'h0,        32'hABCD0000, 0, 4'hD, 3'b000, 32'h0,        32'hABCD0000, 0);
    addVec(0, 0, 4'h4, 6'h00, 32'd5,        32'd5,        32'h0,        32'h0,        32'h0,        1, 4'h4, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 0, 4'hF, 6'h3F, 32'd2,        32'd3,        32'h0,        32'h0,        32'd5,        0, 4'h2, 3'b000, 32'h0,        32'd5,        0);
    addVec(0, 0, 4'hF, 6'h2B, 32'd1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'd1,        0, 4'h8, 3'b000, 32'h0,        32'd1,        0);
    addVec(0, 0, 4'h2, 6'h00, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,        32'h0,        1, 4'h2, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 0, 4'h2, 6'h00, 32'd1,        32'd2,        32'h0,        32'h0,        32'd3,        0, 4'h2, 3'b000, 32'h0,        32'd3,        0);
    // Two stalled cycles with changing inputs hold 3, then reset overrides stall.
    addVec(0, 1, 4'h2, 6'h00, 32'h10,       32'h10,       32'h0,        32'h0,        32'h20,       0, 4'h2, 3'b000, 32'h0,        32'd3,        0);
    addVec(0, 1, 4'h2, 6'h00, 32'd0,        32'd0,        32'h0,        32'h0,        32'h0,        1, 4'h2, 3'b000, 32'h0,        32'd3,        0);
    addVec(1, 1, 4'h2, 6'h00, 32'd1,        32'd1,        32'h0,        32'h0,        32'd2,        0, 4'h2, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 1, 4'h2, 6'h00, 32'd4,        32'd4,        32'h0,        32'h0,        32'd8,        0, 4'h2, 3'b000, 32'h0,        32'h0,        1);
    addVec(0, 0, 4'h2, 6'h00, 32'd4,        32'd4,        32'h0,        32'h0,        32'd8,        0, 4'h2, 3'b000, 32'h0,        32'd8,        0);
    budget = 0;
    while (retired < pushed && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    #2;
    testsRun++;
    if (retired != pushed) begin
      testsFailed++;
      $display("FAIL drain: retired %0d expected %0d", retired, pushed);
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
